// File: rtl/reorder_buffer_if.sv
// Rename/execute <-> reorder buffer signal bundle: allocation, writeback,
// branch resolution, and retirement/free-list return.
interface reorder_buffer_if #(
  parameter int unsigned TAG_W  = 4,
  parameter int unsigned PREG_W = 7,
  parameter int unsigned PC_W   = 32
);
  logic              alloc_valid;
  logic              alloc_ready;
  logic [TAG_W-1:0]  alloc_tag;
  logic [PREG_W-1:0] alloc_pd_new;
  logic [PREG_W-1:0] alloc_pd_old;
  logic              alloc_is_br;
  logic [PC_W-1:0]   alloc_pc;

  logic              wb_valid;
  logic [TAG_W-1:0]  wb_tag;

  logic              br_valid;
  logic [TAG_W-1:0]  br_tag;
  logic              br_mispredict;

  logic              commit_valid;
  logic [TAG_W-1:0]  commit_tag;
  logic [PC_W-1:0]   commit_pc;
  logic              free_en;
  logic [PREG_W-1:0] free_preg;
  logic              mispredict;

  modport master (
    output alloc_valid, alloc_tag, alloc_pd_new, alloc_pd_old, alloc_is_br, alloc_pc,
    output wb_valid, wb_tag, br_valid, br_tag, br_mispredict,
    input  alloc_ready, commit_valid, commit_tag, commit_pc, free_en, free_preg, mispredict
  );

  modport slave (
    input  alloc_valid, alloc_tag, alloc_pd_new, alloc_pd_old, alloc_is_br, alloc_pc,
    input  wb_valid, wb_tag, br_valid, br_tag, br_mispredict,
    output alloc_ready, commit_valid, commit_tag, commit_pc, free_en, free_preg, mispredict
  );
endinterface

// File: rtl/reorder_buffer.sv
// In-order retirement buffer: records completion out of order, commits one
// instruction per cycle in program order, and squashes younger entries on a mispredict.
module reorder_buffer #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned TAG_W  = 4,
  parameter int unsigned PREG_W = 7,
  parameter int unsigned PC_W   = 32
) (
  input  logic            clk,
  input  logic            reset,
  reorder_buffer_if.slave rob
);
  localparam int unsigned CNT_W = TAG_W + 1;

  typedef struct packed {
    logic              is_br;
    logic [PREG_W-1:0] pd_new;
    logic [PREG_W-1:0] pd_old;
    logic [PC_W-1:0]   pc;
  } entry_t;

  entry_t           entries [DEPTH];
  logic [DEPTH-1:0] valid, done, valid_nxt, done_nxt, squash;
  logic [TAG_W-1:0] head, tail, head_nxt, tail_nxt, br_rel;
  logic [CNT_W-1:0] count, count_nxt;
  logic             fire, alloc, flush;
  entry_t           head_entry;
  logic             unused_fields;

  assign head_entry = entries[head];
  // is_br and pd_new are carried per entry for debug visibility only
  assign unused_fields = ^{head_entry.is_br, head_entry.pd_new};

  assign rob.alloc_ready = !reset && (count < CNT_W'(DEPTH)) &&
                           !(rob.br_valid && rob.br_mispredict);

  // Next-state: completion marking, retirement, squash, allocation
  always_comb begin
    fire   = valid[head] && done[head];
    alloc  = rob.alloc_valid && rob.alloc_ready;
    flush  = rob.br_valid && rob.br_mispredict && valid[rob.br_tag];
    br_rel = rob.br_tag - head;

    // Age is distance from head; everything further than the branch is younger
    squash = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (flush && ((TAG_W'(i) - head) > br_rel)) squash[i] = 1'b1;
    end

    valid_nxt = valid;
    done_nxt  = done;
    if (rob.wb_valid && valid[rob.wb_tag]) done_nxt[rob.wb_tag] = 1'b1;
    if (rob.br_valid && valid[rob.br_tag]) done_nxt[rob.br_tag] = 1'b1;
    if (fire) begin
      valid_nxt[head] = 1'b0;
      done_nxt[head]  = 1'b0;
    end
    valid_nxt = valid_nxt & ~squash;
    done_nxt  = done_nxt & ~squash;
    if (alloc) begin
      valid_nxt[tail] = 1'b1;
      done_nxt[tail]  = 1'b0;
    end

    head_nxt = head + TAG_W'(fire);
    if (flush) begin
      tail_nxt  = rob.br_tag + TAG_W'(1);
      count_nxt = CNT_W'(br_rel) + CNT_W'(1) - CNT_W'(fire);
    end else begin
      tail_nxt  = tail + TAG_W'(alloc);
      count_nxt = count + CNT_W'(alloc) - CNT_W'(fire);
    end
  end

  // Payload storage needs no reset; validity is tracked separately
  always_ff @(posedge clk) begin
    if (alloc) begin
      entries[tail] <= '{is_br:  rob.alloc_is_br,
                         pd_new: rob.alloc_pd_new,
                         pd_old: rob.alloc_pd_old,
                         pc:     rob.alloc_pc};
    end
  end

  // Pointers, status bits and registered retirement outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head             <= '0;
      tail             <= '0;
      count            <= '0;
      valid            <= '0;
      done             <= '0;
      rob.commit_valid <= 1'b0;
      rob.commit_tag   <= '0;
      rob.commit_pc    <= '0;
      rob.free_en      <= 1'b0;
      rob.free_preg    <= '0;
      rob.mispredict   <= 1'b0;
    end else begin
      head             <= head_nxt;
      tail             <= tail_nxt;
      count            <= count_nxt;
      valid            <= valid_nxt;
      done             <= done_nxt;
      rob.commit_valid <= fire;
      rob.free_en      <= fire && (head_entry.pd_old != '0);
      rob.mispredict   <= flush;
      if (fire) begin
        rob.commit_tag <= head;
        rob.commit_pc  <= head_entry.pc;
        rob.free_preg  <= head_entry.pd_old;
      end
    end
  end

  alloc_tag_matches_tail: assert property (@(posedge clk) disable iff (reset)
    (rob.alloc_valid && rob.alloc_ready) |-> (rob.alloc_tag == tail));

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed scoreboard bench for reorder_buffer: in-order commit, full/wrap,
// mispredict squash, null free, simultaneous alloc/commit and async reset.
module tb_reorder_buffer;
  localparam int unsigned DEPTH  = 16;
  localparam int unsigned TAG_W  = 4;
  localparam int unsigned PREG_W = 7;
  localparam int unsigned PC_W   = 32;

  typedef struct {
    logic [TAG_W-1:0]  tag;
    logic [PC_W-1:0]   pc;
    logic [PREG_W-1:0] pd_old;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;
  exp_t sb[$];
  logic [TAG_W-1:0] tb_tail = '0;
  logic [PC_W-1:0]  pc_ctr = 32'h8000_0000;

  reorder_buffer_if #(.TAG_W(TAG_W), .PREG_W(PREG_W), .PC_W(PC_W)) rob_if ();

  reorder_buffer #(.DEPTH(DEPTH), .TAG_W(TAG_W), .PREG_W(PREG_W), .PC_W(PC_W)) dut (
    .clk   (clk),
    .reset (reset),
    .rob   (rob_if.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
    end
  endtask

  // One clock; compare any retirement against the scoreboard front
  task automatic cycle();
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check("idle_commit_valid", 64'(rob_if.commit_valid), 64'd0);
    end else if (rob_if.commit_valid) begin
      e = sb.pop_front();
      check("commit_tag", 64'(rob_if.commit_tag), 64'(e.tag));
      check("commit_pc", 64'(rob_if.commit_pc), 64'(e.pc));
      check("free_preg", 64'(rob_if.free_preg), 64'(e.pd_old));
      check("free_en", 64'(rob_if.free_en), 64'(e.pd_old != '0));
    end
  endtask

  task automatic do_alloc(input logic [PREG_W-1:0] pd_old, input logic is_br);
    rob_if.alloc_valid  = 1'b1;
    rob_if.alloc_tag    = tb_tail;
    rob_if.alloc_pd_new = PREG_W'(tb_tail) + PREG_W'(64);
    rob_if.alloc_pd_old = pd_old;
    rob_if.alloc_is_br  = is_br;
    rob_if.alloc_pc     = pc_ctr;
    sb.push_back('{tag: tb_tail, pc: pc_ctr, pd_old: pd_old});
    #1 check("alloc_ready_before_alloc", 64'(rob_if.alloc_ready), 64'd1);
    cycle();
    rob_if.alloc_valid = 1'b0;
    rob_if.alloc_is_br = 1'b0;
    tb_tail = tb_tail + TAG_W'(1);
    pc_ctr  = pc_ctr + 32'd4;
  endtask

  task automatic do_wb(input logic [TAG_W-1:0] tag);
    rob_if.wb_valid = 1'b1;
    rob_if.wb_tag   = tag;
    cycle();
    rob_if.wb_valid = 1'b0;
  endtask

  task automatic do_mispredict(input logic [TAG_W-1:0] tag);
    rob_if.br_valid      = 1'b1;
    rob_if.br_tag        = tag;
    rob_if.br_mispredict = 1'b1;
    #1 check("alloc_ready_during_flush", 64'(rob_if.alloc_ready), 64'd0);
    cycle();
    rob_if.br_valid      = 1'b0;
    rob_if.br_mispredict = 1'b0;
    check("mispredict_pulse", 64'(rob_if.mispredict), 64'd1);
    while (sb.size() > 0 && sb[$].tag != tag) void'(sb.pop_back());
    tb_tail = tag + TAG_W'(1);
  endtask

  task automatic drain(input int budget);
    int k = 0;
    while (sb.size() > 0 && k < budget) begin
      cycle();
      k++;
    end
    check("drain_queue_empty", 64'(sb.size()), 64'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    check("rst_commit_valid", 64'(rob_if.commit_valid), 64'd0);
    check("rst_free_en", 64'(rob_if.free_en), 64'd0);
    check("rst_free_preg", 64'(rob_if.free_preg), 64'd0);
    check("rst_commit_tag", 64'(rob_if.commit_tag), 64'd0);
    check("rst_commit_pc", 64'(rob_if.commit_pc), 64'd0);
    check("rst_mispredict", 64'(rob_if.mispredict), 64'd0);
    check("rst_count", 64'(dut.count), 64'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    sb.delete();
    tb_tail = '0;
    #1 check("alloc_ready_after_reset", 64'(rob_if.alloc_ready), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    rob_if.alloc_valid   = 1'b0;
    rob_if.alloc_tag     = '0;
    rob_if.alloc_pd_new  = '0;
    rob_if.alloc_pd_old  = '0;
    rob_if.alloc_is_br   = 1'b0;
    rob_if.alloc_pc      = '0;
    rob_if.wb_valid      = 1'b0;
    rob_if.wb_tag        = '0;
    rob_if.br_valid      = 1'b0;
    rob_if.br_tag        = '0;
    rob_if.br_mispredict = 1'b0;

    // Reset, then out-of-order completion retires in order
    do_reset();
    do_alloc(7'd5, 1'b0);
    do_alloc(7'd6, 1'b0);
    do_alloc(7'd7, 1'b0);
    do_wb(4'd2);
    do_wb(4'd0);
    do_wb(4'd1);
    drain(10);

    // Null previous mapping retires without a free
    do_alloc(7'd0, 1'b0);
    do_wb(4'd3);
    drain(10);

    // Fill to capacity, retire one, wrap tail back to 0
    do_reset();
    for (int i = 0; i < 16; i++) do_alloc(7'(20 + i), 1'b0);
    check("full_alloc_ready", 64'(rob_if.alloc_ready), 64'd0);
    check("full_count", 64'(dut.count), 64'd16);
    do_wb(4'd0);
    cycle();
    check("alloc_ready_after_free_slot", 64'(rob_if.alloc_ready), 64'd1);
    do_alloc(7'd50, 1'b0);
    check("wrapped_tail", 64'(dut.tail), 64'd1);
    check("wrapped_count", 64'(dut.count), 64'd16);

    // Mispredict on tag 3 squashes 4..7
    do_reset();
    for (int i = 0; i < 8; i++) do_alloc(7'(30 + i), i == 3);
    do_mispredict(4'd3);
    check("flush_tail", 64'(dut.tail), 64'd4);
    check("flush_count", 64'(dut.count), 64'd4);
    cycle();
    check("mispredict_one_cycle", 64'(rob_if.mispredict), 64'd0);
    do_wb(4'd5);
    check("squashed_wb_ignored", 64'(dut.done[5]), 64'd0);
    do_wb(4'd0);
    do_wb(4'd1);
    do_wb(4'd2);
    drain(10);
    check("post_flush_count", 64'(dut.count), 64'd0);

    // count=5 with simultaneous alloc and commit
    for (int i = 0; i < 5; i++) do_alloc(7'(40 + i), 1'b0);
    check("count_five", 64'(dut.count), 64'd5);
    do_wb(4'd4);
    do_alloc(7'd45, 1'b0);
    check("sim_count", 64'(dut.count), 64'd5);
    check("sim_head", 64'(dut.head), 64'd5);
    check("sim_tail", 64'(dut.tail), 64'd10);

    // Async reset mid-stream with a commit on the outputs
    for (int i = 0; i < 6; i++) do_alloc(7'(50 + i), 1'b0);
    check("count_eleven", 64'(dut.count), 64'd11);
    do_wb(4'd6);
    do_wb(4'd5);
    cycle();
    check("pre_reset_commit_valid", 64'(rob_if.commit_valid), 64'd1);
    check("pre_reset_count", 64'(dut.count), 64'd10);
    do_reset();
    do_wb(4'd6);
    do_wb(4'd7);
    check("stale_wb_done", 64'(dut.done), 64'd0);
    check("stale_wb_valid", 64'(dut.valid), 64'd0);
    do_alloc(7'd9, 1'b0);
    do_wb(4'd0);
    drain(10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
